rsa_job_sched: RTL and testbench

//  Request front-end placed directly upstream of the modular-exponentiation engine.
//  - Accepts (base, exponent, modulus, tag) jobs on a valid/ready channel and queues them in a small FIFO.
//  - Issues one job at a time to the engine as a single-cycle start pulse, holding operands stable.
//  - Returns each result with its tag on a valid/ready output channel.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/rsa_req_fifo.sv | 61 ++++++
 rtl/rsa_job_sched.sv | 177 +++++++++++++++++
 tb/tb_rsa_job_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the modular-exponentiation request scheduler: default widths,
// scheduler FSM states and the queued request record.
package rsa_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } sched_state_t;

    typedef struct packed {
        logic [DEF_WORD_W-1:0] base;
        logic [DEF_WORD_W-1:0] exp;
        logic [DEF_WORD_W-1:0] mod;
        logic [DEF_TAG_W-1:0]  tag;
    } rsa_req_t;

endpackage

// File: rtl/rsa_req_fifo.sv
// Small request FIFO for the scheduler; item type is a parameter so the top can
// pass a record sized to its own WORD_W/TAG_W.
module rsa_req_fifo
    import rsa_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type item_t = rsa_req_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  item_t                  push_data,
    input  logic                   pop,
    output item_t                  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    item_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // A pop never frees room for a push in the same cycle: push is gated by full.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rsa_job_sched.sv
// Request front-end for the modular-exponentiation engine: queues jobs, issues them
// one at a time, returns tagged results. Define RSA_SCHED_STATS_EN for job/error counters.
module rsa_job_sched
    import rsa_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int DEPTH      = 4,
    parameter int ENG_CYCLES = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_base,
    input  logic [WORD_W-1:0] in_exp,
    input  logic [WORD_W-1:0] in_mod,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              eng_start,
    output logic [WORD_W-1:0] eng_base,
    output logic [WORD_W-1:0] eng_exp,
    output logic [WORD_W-1:0] eng_mod,
    input  logic [WORD_W-1:0] eng_result,
    input  logic              eng_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
`ifdef RSA_SCHED_STATS_EN
    ,
    output logic [15:0]       stat_jobs,
    output logic [15:0]       stat_errs
`endif
);

    localparam int                CNT_W    = $clog2(ENG_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ENG_CYCLES - 1);

    typedef struct packed {
        logic [WORD_W-1:0] base;
        logic [WORD_W-1:0] exp;
        logic [WORD_W-1:0] mod;
        logic [TAG_W-1:0]  tag;
    } req_t;

    sched_state_t            state;
    sched_state_t            state_nxt;
    req_t                    push_data;
    req_t                    head;
    req_t                    hold;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    unused_fifo_count;
    logic                    ready_en;
    logic                    pop;
    logic                    bad_mod;
    logic                    complete;
    logic                    done_prev;
    logic [CNT_W-1:0]        cnt;
    logic [WORD_W-1:0]       res_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    err_q;

    assign push_data = '{base: in_base, exp: in_exp, mod: in_mod, tag: in_tag};

    rsa_req_fifo #(
        .DEPTH  (DEPTH),
        .item_t (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign unused_fifo_count = &{1'b0, fifo_count};

    // ready_en keeps in_ready low while reset is asserted and for the release cycle.
    assign in_ready   = ready_en && !fifo_full;
    assign bad_mod    = (head.mod < WORD_W'(2));
    assign complete   = (state == WAIT) && ((eng_done && !done_prev) || (cnt == CNT_LAST));
    assign eng_base   = hold.base;
    assign eng_exp    = hold.exp;
    assign eng_mod    = hold.mod;
    assign out_result = res_q;
    assign out_tag    = tag_q;
    assign out_err    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = bad_mod ? OUT : ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (complete) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eng_start = (state == ISSUE);
        out_valid = (state == OUT);
        pop       = (state == IDLE) && !fifo_empty;
    end

    // Holding registers, completion counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            hold      <= '0;
            done_prev <= 1'b0;
            cnt       <= '0;
            res_q     <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            done_prev <= eng_done;
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold <= head;
                        if (bad_mod) begin
                            res_q <= '0;
                            tag_q <= head.tag;
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (complete) begin
                        res_q <= eng_result;
                        tag_q <= hold.tag;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RSA_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_jobs <= '0;
            stat_errs <= '0;
        end else if (out_valid && out_ready) begin
            stat_jobs <= sat_inc(stat_jobs);
            if (err_q) begin
                stat_errs <= sat_inc(stat_errs);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rsa_job_sched.sv
// Self-checking bench for rsa_job_sched: directed vector table, corner-case sequences
// and randomized traffic against a queue-based reference model with a bench engine.
module tb_rsa_job_sched;

    localparam int WW = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_base = '0;
    logic [WW-1:0] in_exp = '0;
    logic [WW-1:0] in_mod = '0;
    logic [TW-1:0] in_tag = '0;
    logic          eng_start;
    logic [WW-1:0] eng_base;
    logic [WW-1:0] eng_exp;
    logic [WW-1:0] eng_mod;
    logic [WW-1:0] eng_result = '0;
    logic          eng_done = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic          out_err;
`ifdef RSA_SCHED_STATS_EN
    logic [15:0]   stat_jobs;
    logic [15:0]   stat_errs;
`endif

    always #5 clk = ~clk;

    rsa_job_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_base    (in_base),
        .in_exp     (in_exp),
        .in_mod     (in_mod),
        .in_tag     (in_tag),
        .eng_start  (eng_start),
        .eng_base   (eng_base),
        .eng_exp    (eng_exp),
        .eng_mod    (eng_mod),
        .eng_result (eng_result),
        .eng_done   (eng_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err)
`ifdef RSA_SCHED_STATS_EN
        ,
        .stat_jobs  (stat_jobs),
        .stat_errs  (stat_errs)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        longint unsigned r, x, mm;
        if (m < 2) return 32'd0;
        mm = 64'(m);
        r  = 64'd1 % mm;
        x  = 64'(b) % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return 32'(r);
    endfunction

    // Bench engine: computes the answer at start, raises done after a latency
    // (single-cycle pulse), or holds done high permanently in sticky mode.
    bit sticky = 1'b0;
    int lat_force = -1;
    int left = 0;
    bit busy = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy     = 1'b0;
            eng_done = sticky;
        end else begin
            if (!sticky) eng_done = 1'b0;
            if (eng_start) begin
                eng_result = modexp(eng_base, eng_exp, eng_mod);
                left       = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 12));
                busy       = 1'b1;
            end else if (busy) begin
                if (left == 0) begin
                    busy = 1'b0;
                    if (!sticky) eng_done = 1'b1;
                end else begin
                    left--;
                end
            end
            if (sticky) eng_done = 1'b1;
        end
    end

    // Reference model: every accepted request yields one result, in acceptance order.
    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_starts = 0;
    int   n_outs = 0;
    bit   prev_start = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_start = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e.err = (in_mod < 2);
                e.res = e.err ? 32'd0 : modexp(in_base, in_exp, in_mod);
                e.tag = in_tag;
                exp_q.push_back(e);
            end
            if (eng_start) begin
                n_starts++;
                chk("start_one_cycle", 64'(prev_start), 64'd0);
            end
            prev_start = eng_start;
            if (out_valid && out_ready) begin
                n_outs++;
                chk("sb_expected_present", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_result", 64'(out_result), 64'(e.res));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                    chk("sb_err", 64'(out_err), 64'(e.err));
                end
            end
        end
    end

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                        input logic [3:0] t);
        bit ok = 1'b0;
        in_base  = b;
        in_exp   = e;
        in_mod   = m;
        in_tag   = t;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int lim, output int n);
        n = 0;
        while (n < lim) begin
            @(negedge clk);
            n++;
            if (out_valid) return;
        end
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_start(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (eng_start) return;
        end
        chk("wait_eng_start", 64'(eng_start), 64'd1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] ex;
        logic [31:0] md;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int n;
        int s0;
        int s1;
        int o0;
        logic [31:0] snap_res;
        logic [3:0]  snap_tag;

        tbl[0] = '{32'd4,  32'd13, 32'd497,  4'd3, 32'd445, 1'b0};
        tbl[1] = '{32'd7,  32'd2,  32'd1,    4'd5, 32'd0,   1'b1};
        tbl[2] = '{32'd2,  32'd10, 32'd1000, 4'd1, 32'd24,  1'b0};
        tbl[3] = '{32'd3,  32'd0,  32'd7,    4'd2, 32'd1,   1'b0};
        tbl[4] = '{32'd5,  32'd3,  32'd13,   4'd4, 32'd8,   1'b0};
        tbl[5] = '{32'd9,  32'd9,  32'd0,    4'd6, 32'd0,   1'b1};
        tbl[6] = '{32'd10, 32'd1,  32'd3,    4'd7, 32'd1,   1'b0};
        tbl[7] = '{32'd2,  32'd5,  32'd2,    4'd8, 32'd0,   1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_eng_ops", 64'(eng_base | eng_exp | eng_mod), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Directed vector table, one job at a time
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s0 = n_starts;
            send(tbl[i].base, tbl[i].ex, tbl[i].md, tbl[i].tag);
            wait_out(100, n);
            chk($sformatf("tbl%0d_result", i), 64'(out_result), 64'(tbl[i].res));
            chk($sformatf("tbl%0d_tag", i), 64'(out_tag), 64'(tbl[i].tag));
            chk($sformatf("tbl%0d_err", i), 64'(out_err), 64'(tbl[i].err));
            chk($sformatf("tbl%0d_starts", i), 64'(n_starts - s0), tbl[i].err ? 64'd0 : 64'd1);
            if (tbl[i].err) chk($sformatf("tbl%0d_bypass_lat_le3", i), 64'(n <= 3), 64'd1);
            @(posedge clk);
            #1;
        end

        // Fill FIFO with results blocked, then hold backpressure
        out_ready = 1'b0;
        o0 = n_outs;
        for (int k = 0; k < 5; k++) begin
            send(32'(k + 2), 32'(k + 3), 32'(1000 + k), 4'(k + 1));
        end
        @(negedge clk);
        chk("fill_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_base = 32'd3; in_exp = 32'd3; in_mod = 32'd11; in_tag = 4'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_no_accept", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(100, n);
        snap_res = out_result;
        snap_tag = out_tag;
        s1 = n_starts;
        chk("fill_first_tag", 64'(snap_tag), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(out_result), 64'(snap_res));
            chk("bp_tag", 64'(out_tag), 64'(snap_tag));
        end
        chk("bp_no_start", 64'(n_starts - s1), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("fill_drain");
        chk("fill_out_count", 64'(n_outs - o0), 64'd5);

        // Sticky done: every job completes by timeout
        @(posedge clk);
        #1;
        sticky = 1'b1;
        send(32'd4, 32'd13, 32'd497, 4'd3);
        send(32'd3, 32'd5, 32'd101, 4'd6);
        for (int j = 0; j < 2; j++) begin
            wait_start(100);
            wait_out(100, n);
            chk($sformatf("sticky%0d_timeout_lat", j), 64'(n), 64'd35);
        end
        drain("sticky_drain");
        @(posedge clk);
        #1;
        sticky = 1'b0;

        // Randomized traffic with random backpressure
        o0 = n_outs;
        for (int c = 0; c < 2000; c++) begin
            bit acc;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc || !in_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    in_base  = $urandom;
                    in_exp   = $urandom;
                    in_mod   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom;
                    in_tag   = 4'($urandom_range(0, 15));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        chk("rand_progress", 64'(n_outs > o0 + 50), 64'd1);

        // Reset while a job is in flight and another is queued
        @(posedge clk);
        #1;
        lat_force = 30;
        send(32'd4, 32'd13, 32'd497, 4'd10);
        send(32'd2, 32'd10, 32'd1000, 4'd11);
        wait_start(100);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_eng_start", 64'(eng_start), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_result", 64'(out_result), 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
        chk("midrst_eng_ops", 64'(eng_base | eng_exp | eng_mod), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s0 = n_starts;
        o0 = n_outs;
        repeat (60) @(negedge clk);
        chk("midrst_no_restart", 64'(n_starts - s0), 64'd0);
        chk("midrst_no_result", 64'(n_outs - o0), 64'd0);
        chk("midrst_out_valid_after", 64'(out_valid), 64'd0);
        chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
        lat_force = -1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
